serial_add_ctrl: RTL and testbench

- Bit-serial adder controller.
- Instantiates exactly one one-bit full_adder cell and reuses it over WIDTH clock cycles to add two WIDTH-bit operands, LSB first.
- Uses a start/busy/done handshake and a result register that holds its value until the next operation.
- Used where area matters more than latency. It is the sequencing layer above the team's one-bit full adder.

---
 rtl/serial_add_ctrl.sv | 153 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell reused over WIDTH cycles, LSB first.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for a - b (cout=1 means no borrow).

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic sum_c,
    output logic carry_c
);
    assign sum_c   = a ^ b ^ ci;
    assign carry_c = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_d, done_d, cout_d;
    logic [WIDTH-1:0] sum_d;

    logic             fa_s, fa_co;
    logic             load;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [WIDTH-1:0] s_shifted;

    full_adder u_fa (
        .a       (a_sh_q[0]),
        .b       (b_sh_q[0]),
        .ci      (carry_q),
        .sum_c   (fa_s),
        .carry_c (fa_co)
    );

    // Operand conditioning at load: subtraction is a + ~b + 1
`ifdef SERIAL_ADD_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // New sum bit enters at the MSB end; written without slices so WIDTH=1 is legal
    assign s_shifted = (s_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        count_d = count_q;
        busy_d  = busy;
        done_d  = 1'b0;
        sum_d   = sum;
        cout_d  = cout;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) load = 1'b1;
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = s_shifted;
                carry_d = fa_co;
                count_d = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = s_shifted;
                    cout_d  = fa_co;
                end
            end
            DONE: begin
                if (start) load = 1'b1;
                else       state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Shared operand capture for IDLE and back-to-back DONE starts
        if (load) begin
            a_sh_d  = a;
            b_sh_d  = b_load;
            carry_d = carry_load;
            count_d = '0;
            state_d = RUN;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            count_q <= count_d;
            busy    <= busy_d;
            done    <= done_d;
            sum     <= sum_d;
            cout    <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: driver pushes expected results, monitor checks on done.
// Define SERIAL_ADD_SUB_EN for both files to exercise subtraction.

module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH:0] res;
        int             cyc;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub_v;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int   tests;
    int   fails;
    int   cyc;
    exp_t q[$];

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub_v),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, subtraction as a - b with a no-borrow flag
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                             input logic mc, input logic ms);
        longint unsigned x, y;
        x = 64'(ma);
        y = 64'(mb);
        if (ms) return {x >= y, WIDTH'(x - y)};
        return (WIDTH + 1)'(x + y + 64'(mc));
    endfunction

    // Drive a start; 'now' means we are already at the DONE-cycle negedge (back-to-back)
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                         input logic tc, input logic ts, input bit now);
        exp_t e;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        a     = ta;
        b     = tbv;
        cin   = tc;
        sub_v = ts;
        start = 1'b1;
        e.res = model(ta, tbv, tc, ts);
        e.cyc = cyc + 1 + WIDTH;
        q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
    endtask

    // A start during RUN that must have no effect
    task automatic stray_start();
        @(posedge clk);
        #1;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        cin   = 1'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 4 * WIDTH + 8);
        chk("done_timeout", 64'(done), 64'(1));
    endtask

    // Monitor: reset flushes the scoreboard; done pops and compares; otherwise outputs must hold
    initial begin : monitor
        logic           r;
        logic [WIDTH:0] hold;
        exp_t           e;
        hold = '0;
        forever begin
            @(posedge clk);
            r = rst;
            @(negedge clk);
            if (r) begin
                q.delete();
                hold = '0;
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_done", 64'(done), 64'(0));
                chk("rst_result", 64'({cout, sum}), 64'(0));
            end else if (done) begin
                chk("spurious_done", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("result", 64'({cout, sum}), 64'(e.res));
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                    chk("busy_at_done", 64'(busy), 64'(0));
                    hold = e.res;
                end
            end else begin
                chk("result_held", 64'({cout, sum}), 64'(hold));
            end
        end
    end

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [WIDTH:0] first;
        bit             b2b;
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b1;
        a     = 8'h5A;
        b     = 8'h33;
        cin   = 1'b1;
        sub_v = 1'b0;

        // Reset held with start high: nothing may begin
        repeat (2) begin
            @(negedge clk);
            chk("reset_busy", 64'(busy), 64'(0));
        end
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", 64'(busy), 64'(0));

        // Basic add with busy window
        issue(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= WIDTH + 1; i++) begin
            @(negedge clk);
            chk("busy_window", 64'(busy), 64'(i <= WIDTH));
            chk("done_window", 64'(done), 64'(i == WIDTH + 1));
        end
        chk("basic_sum", 64'(sum), 64'(8'hE1));

        // Carry chains
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        wait_done();
        chk("carry1", 64'({cout, sum}), 64'(9'h100));
        issue(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        wait_done();
        chk("carry2", 64'({cout, sum}), 64'(9'h1FF));

        // Stray start in RUN ignored; back-to-back start in DONE accepted
        issue(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0);
        first = model(8'hA5, 8'h3C, 1'b0, 1'b0);
        @(posedge clk);
        stray_start();
        wait_done();
        issue(8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_in_run", 64'({cout, sum}), 64'(first));
        wait_done();

        // Reset in the middle of an operation
        issue(8'h77, 8'h99, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);
        chk("abort_queue_empty", 64'(q.size()), 64'(0));
        issue(8'h0F, 8'hF0, 1'b1, 1'b0, 1'b0);
        wait_done();

`ifdef SERIAL_ADD_SUB_EN
        issue(8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
        wait_done();
        chk("sub1", 64'({cout, sum}), 64'(9'h10F));
        issue(8'h01, 8'h02, 1'b0, 1'b1, 1'b0);
        wait_done();
        chk("sub2", 64'({cout, sum}), 64'(9'h0FF));
`endif

        // Randomized traffic with stray starts, gaps and back-to-back issues
        b2b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic rs;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), rs, b2b);
            if ($urandom_range(0, 3) == 0) stray_start();
            wait_done();
            b2b = 1'($urandom_range(0, 1));
            if (!b2b) repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (WIDTH + 4) @(negedge clk);
        chk("drain_queue_empty", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
